// File: rtl/imm_field_encoder.sv
// imm_field_encoder: packs a 32-bit immediate into the immediate fields of an
// instruction word. This is the inverse of the ID-stage sign extender. It has
// a two-stage valid/ready pipeline, an output address counter and
// delivered/errored beat counters. The block feeds instruction memory in the
// program loader.
module imm_field_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       base_inst,
  input  logic [31:0]       imm,
  input  logic [3:0]        imm_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic              out_err,
  output logic [ADDR_W-1:0] out_addr,
  output logic [CNT_W-1:0]  inst_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  // imm_sel[2:0] format codes, identical to the decoder's sign-extender select.
  localparam logic [2:0] IMM_TYPE1 = 3'd1;  // U
  localparam logic [2:0] IMM_TYPE2 = 3'd2;  // J
  localparam logic [2:0] IMM_TYPE3 = 3'd3;  // I
  localparam logic [2:0] IMM_TYPE4 = 3'd4;  // B, no implicit LSB
  localparam logic [2:0] IMM_TYPE5 = 3'd5;  // S
  localparam logic [2:0] IMM_TYPE6 = 3'd6;  // shamt

  logic        is_unsigned;
  logic        uni_31_20;   // imm[31:20] all-equal: fits a 21-bit signed J offset
  logic        uni_31_11;   // imm[31:11] all-equal: fits a 12-bit signed field
  logic        zero_31_12;  // imm fits a 12-bit unsigned field
  logic [31:0] enc_inst;
  logic        enc_err;

  logic        s1_valid;
  logic [31:0] s1_inst;
  logic        s1_err;
  logic        s2_load;
  logic        out_fire;

  assign is_unsigned = imm_sel[3];
  assign uni_31_20   = (&imm[31:20]) | ~(|imm[31:20]);
  assign uni_31_11   = (&imm[31:11]) | ~(|imm[31:11]);
  assign zero_31_12  = ~(|imm[31:12]);

  // Field encoder: overwrite only the selected format's immediate bits and flag
  // values the decoder could not reproduce.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    enc_inst = base_inst;
    enc_err  = 1'b0;
    case (imm_sel[2:0])
      IMM_TYPE1: begin
        enc_inst[31:12] = imm[31:12];
        enc_err         = |imm[11:0];
      end
      IMM_TYPE2: begin
        if (is_unsigned) begin
          enc_inst[31:12] = imm[20:1];
          enc_err         = imm[0] | (|imm[31:21]);
        end else begin
          enc_inst[31]    = imm[20];
          enc_inst[30:21] = imm[10:1];
          enc_inst[20]    = imm[11];
          enc_inst[19:12] = imm[19:12];
          enc_err         = imm[0] | ~uni_31_20;
        end
      end
      IMM_TYPE3: begin
        enc_inst[31:20] = imm[11:0];
        enc_err         = is_unsigned ? ~zero_31_12 : ~uni_31_11;
      end
      IMM_TYPE4: begin
        enc_inst[31]    = imm[11];
        enc_inst[7]     = imm[10];
        enc_inst[30:25] = imm[9:4];
        enc_inst[11:8]  = imm[3:0];
        enc_err         = ~uni_31_11;
      end
      IMM_TYPE5: begin
        enc_inst[31:25] = imm[11:5];
        enc_inst[11:7]  = imm[4:0];
        enc_err         = is_unsigned ? ~zero_31_12 : ~uni_31_11;
      end
      IMM_TYPE6: begin
        enc_inst[24:20] = imm[4:0];
        enc_err         = |imm[31:5];
      end
      default: begin
        enc_err = 1'b1;
      end
    endcase
  end

  // The output stage loads when empty or draining. S1 refills whenever its
  // beat moves on, or when it is empty.
  assign s2_load  = ~out_valid | out_ready;
  assign in_ready = ~flush & (~s1_valid | s2_load);
  assign out_fire = out_valid & out_ready;

  // Two-stage pipeline: S1 holds the encoded beat, S2 is the output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s1_inst   <= '0;
      s1_err    <= 1'b0;
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_err   <= 1'b0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments, so every flop
      // samples pre-edge values and S1->S2 transfers cannot race.
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_inst <= s1_inst;
          out_err  <= s1_err;
        end
      end
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_inst <= enc_inst;
          s1_err  <= enc_err;
        end
      end
    end
  end

  // Write address and beat counters. They advance on each output handshake;
  // flush takes priority over that handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_addr <= BASE_ADDR;
      inst_cnt <= '0;
      err_cnt  <= '0;
    end else if (flush) begin
      out_addr <= BASE_ADDR;
      inst_cnt <= '0;
      err_cnt  <= '0;
    end else if (out_fire) begin
      out_addr <= out_addr + ADDR_W'(4);
      inst_cnt <= inst_cnt + CNT_W'(1);
      if (out_err && (err_cnt != '1)) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imm_field_encoder.sv
// Directed bench for imm_field_encoder. Narrow address and counter widths make
// address wrap, count wrap and error-count saturation reachable in a short run.
module tb_imm_field_encoder;

  localparam int ADDR_W = 6;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       base_inst;
  logic [31:0]       imm;
  logic [3:0]        imm_sel;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic              out_err;
  logic [ADDR_W-1:0] out_addr;
  logic [CNT_W-1:0]  inst_cnt;
  logic [CNT_W-1:0]  err_cnt;

  imm_field_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR('0), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .base_inst(base_inst), .imm(imm), .imm_sel(imm_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err), .out_addr(out_addr),
    .inst_cnt(inst_cnt), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Bench-side model of the address and counter registers.
  logic [ADDR_W-1:0] exp_addr;
  logic [CNT_W-1:0]  exp_cnt;
  logic [CNT_W-1:0]  exp_ecnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference ID-stage sign extender, used for round-trip checks.
  function automatic logic [31:0] sign_ext(input logic [31:0] i, input logic [3:0] sel);
    case (sel[2:0])
      3'd1: return {i[31:12], 12'b0};
      3'd2: return sel[3] ? {11'b0, i[31:12], 1'b0}
                          : {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      3'd3: return sel[3] ? {20'b0, i[31:20]} : {{20{i[31]}}, i[31:20]};
      3'd4: return {{20{i[31]}}, i[31], i[7], i[30:25], i[11:8]};
      3'd5: return sel[3] ? {20'b0, i[31:25], i[11:7]} : {{20{i[31]}}, i[31:25], i[11:7]};
      3'd6: return {27'b0, i[24:20]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] field_mask(input logic [2:0] t);
    case (t)
      3'd1, 3'd2: return 32'hFFFFF000;
      3'd3:       return 32'hFFF00000;
      3'd4, 3'd5: return 32'hFE000F80;
      3'd6:       return 32'h01F00000;
      default:    return 32'h0;
    endcase
  endfunction

  task automatic clear_model();
    exp_addr = '0;
    exp_cnt  = '0;
    exp_ecnt = '0;
  endtask

  // One isolated beat with out_ready=1. Entry and exit: 1 ns after a rising
  // edge, with the pipeline empty. Checks latency, error flag, address and counters.
  task automatic run_beat(input string tag, input logic [31:0] base, input logic [31:0] im,
                          input logic [3:0] sel, input logic exp_err, output logic [31:0] got);
    base_inst = base; imm = im; imm_sel = sel; in_valid = 1'b1;
    @(negedge clk); check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); check({tag, ".lat1"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".err"}, 32'(out_err), 32'(exp_err));
    check({tag, ".addr"}, 32'(out_addr), 32'(exp_addr));
    got = out_inst;
    @(posedge clk); #1;
    exp_addr = exp_addr + ADDR_W'(4);
    exp_cnt  = exp_cnt + CNT_W'(1);
    if (exp_err && exp_ecnt != '1) exp_ecnt = exp_ecnt + CNT_W'(1);
    check({tag, ".inst_cnt"}, 32'(inst_cnt), 32'(exp_cnt));
    check({tag, ".err_cnt"}, 32'(err_cnt), 32'(exp_ecnt));
  endtask

  task automatic single(input string tag, input logic [31:0] base, input logic [31:0] im,
                        input logic [3:0] sel, input logic [31:0] exp_inst, input logic exp_err);
    logic [31:0] got;
    run_beat(tag, base, im, sel, exp_err, got);
    check({tag, ".inst"}, got, exp_inst);
  endtask

  // A random representable immediate must survive the encode/decode round trip.
  task automatic rt_beat();
    logic [2:0]  t;
    logic [3:0]  sel;
    logic [31:0] r, im, base, got;
    t    = 3'($urandom_range(1, 6));
    sel  = {1'($urandom_range(0, 1)), t};
    r    = $urandom;
    base = $urandom;
    case (t)
      3'd1: im = {r[31:12], 12'b0};
      3'd2: im = sel[3] ? {11'b0, r[20:1], 1'b0} : {{11{r[20]}}, r[20:1], 1'b0};
      3'd3, 3'd5: im = sel[3] ? {20'b0, r[11:0]} : {{20{r[11]}}, r[11:0]};
      3'd4: im = {{20{r[11]}}, r[11:0]};
      default: im = {27'b0, r[4:0]};
    endcase
    run_beat("rt", base, im, sel, 1'b0, got);
    check("rt.decode", sign_ext(got, sel), im);
    check("rt.passthru", got & ~field_mask(t), base & ~field_mask(t));
  endtask

  // Check that reset or flush left the block in its post-reset state.
  task automatic check_idle(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".addr"}, 32'(out_addr), 32'd0);
    check({tag, ".inst_cnt"}, 32'(inst_cnt), 32'd0);
    check({tag, ".err_cnt"}, 32'(err_cnt), 32'd0);
  endtask

  // Watch a few cycles and report whether any output beat appears.
  task automatic watch_quiet(input string tag);
    logic seen;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk); if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    check({tag, ".no_beat"}, 32'(seen), 32'd0);
  endtask

  // Put two beats in flight (S2 held by out_ready=0, S1 full).
  task automatic fill_two();
    out_ready = 1'b0;
    base_inst = 32'h00000037; imm = 32'hAAAAA000; imm_sel = 4'd1; in_valid = 1'b1;
    @(posedge clk); #1 imm = 32'h55555000;
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  int          bp_idx, stall_left, prod_ok;
  logic        saw_drop, prev_stall, acc;
  logic [31:0] prev_inst;
  logic [ADDR_W-1:0] prev_addr;

  initial begin
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    base_inst = '0; imm = '0; imm_sel = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    check_idle("rst");
    check("rst.out_inst", out_inst, 32'h0);
    check("rst.out_err", 32'(out_err), 32'd0);
    #9 reset = 1'b1;
    @(negedge clk); check("rst.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    clear_model();

    // Directed formats; 16 beats so address and inst_cnt wrap back to 0.
    single("u",      32'h00000037, 32'h12345000, 4'h1, 32'h12345037, 1'b0);
    single("i_m1",   32'h00000013, 32'hFFFFFFFF, 4'h3, 32'hFFF00013, 1'b0);
    single("i_800",  32'h00000013, 32'h00000800, 4'h3, 32'h80000013, 1'b1);
    single("j_800",  32'h0000006F, 32'h00000800, 4'h2, 32'h0010006F, 1'b0);
    single("j_801",  32'h0000006F, 32'h00000801, 4'h2, 32'h0010006F, 1'b1);
    single("sh_5",   32'h00001013, 32'h00000005, 4'h6, 32'h00501013, 1'b0);
    single("sh_20",  32'h00001013, 32'h00000020, 4'h6, 32'h00001013, 1'b1);
    single("b",      32'h00000063, 32'h000004D5, 4'h4, 32'h1A0005E3, 1'b0);
    single("s_neg",  32'h00002023, 32'hFFFFF800, 4'h5, 32'h80002023, 1'b0);
    single("s_uns",  32'h00002023, 32'h00000FFF, 4'hD, 32'hFE002FA3, 1'b0);
    single("j_uns",  32'h0000006F, 32'h001FFFFE, 4'hA, 32'hFFFFF06F, 1'b0);
    single("i_uns",  32'h00000013, 32'h00000800, 4'hB, 32'h80000013, 1'b0);
    single("sel0",   32'h12345678, 32'h00000000, 4'h0, 32'h12345678, 1'b1);
    single("sel7",   32'h87654321, 32'h00000004, 4'h7, 32'h87654321, 1'b1);
    single("u_lo",   32'h00000037, 32'h12345001, 4'h1, 32'h12345037, 1'b1);
    single("b_800",  32'h00000063, 32'h00000800, 4'h4, 32'h80000063, 1'b1);

    // Async reset pulse in the middle of a cycle, with two beats in flight.
    fill_two();
    @(negedge clk);
    check("rst2.full", 32'(in_ready), 32'd0);
    #2 reset = 1'b0;
    #1 check_idle("rst2");
    #1 reset = 1'b1;
    out_ready = 1'b1;
    clear_model();
    @(posedge clk); #1;
    @(negedge clk); check("rst2.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    watch_quiet("rst2");

    // Backpressure: 4 back-to-back beats, out_ready low 3 clk after the 1st.
    bp_idx = 0; stall_left = 0; prod_ok = 1; saw_drop = 1'b0; prev_stall = 1'b0;
    prev_inst = '0; prev_addr = '0;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          base_inst = 32'h00000037; imm = 32'((k + 1) << 12); imm_sel = 4'd1;
          in_valid = 1'b1;
          acc = 1'b0;
          for (int w = 0; w < 20 && !acc; w++) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
          end
          if (!acc) prod_ok = 0;
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 40 && bp_idx < 4; c++) begin
          @(negedge clk);
          if (!in_ready) saw_drop = 1'b1;
          if (out_valid && !out_ready && prev_stall) begin
            check("bp.hold_inst", out_inst, prev_inst);
            check("bp.hold_addr", 32'(out_addr), 32'(prev_addr));
          end
          if (out_valid && out_ready) begin
            check("bp.inst", out_inst, 32'(((bp_idx + 1) << 12) | 32'h37));
            check("bp.addr", 32'(out_addr), 32'(bp_idx * 4));
            bp_idx++;
            if (bp_idx == 1) stall_left = 3;
          end
          prev_stall = out_valid && !out_ready;
          prev_inst  = out_inst;
          prev_addr  = out_addr;
          @(posedge clk); #1;
          if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            out_ready = 1'b1;
          end
        end
      end
    join
    out_ready = 1'b1;
    check("bp.delivered", 32'(bp_idx), 32'd4);
    check("bp.accepted", 32'(prod_ok), 32'd1);
    check("bp.in_ready_drop", 32'(saw_drop), 32'd1);
    check("bp.inst_cnt", 32'(inst_cnt), 32'd4);
    check("bp.addr_next", 32'(out_addr), 32'd16);
    watch_quiet("bp");

    // Flush with two beats in flight; out_ready=1 makes a handshake coincide.
    fill_two();
    out_ready = 1'b1; flush = 1'b1;
    imm = 32'h77777000; in_valid = 1'b1;
    @(negedge clk); check("fl.in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    check_idle("fl");
    watch_quiet("fl");
    clear_model();

    // err_cnt saturates at all-ones; inst_cnt and address wrap.
    for (int i = 0; i < 17; i++)
      single("sat", 32'h00000013, 32'h0, 4'h0, 32'h00000013, 1'b1);

    for (int i = 0; i < 150; i++) rt_beat();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
